// File: rtl/led_matrix_driver.sv
// led_matrix_driver
//   Row-scanned driver for the 4x4 beat-indicator LED matrix. Each row gets
//   a slot of SCAN_DIV clocks. The slot opens with BLANK_CYCLES of all
//   columns off (anti-ghosting), then drives that row for the rest of the
//   slot. Beat b sits at row b[3:2], column b[1:0]. Programmed beats glow dim
//   through a 4-bit PWM. The playhead beat is fully lit.
//   Optional feature, macro CURSOR_BLINK_EN: a blinking edit cursor that
//   overrides every other LED state.
//
// Ports
//   clk           system clock
//   rst_n         synchronous reset, active-low
//   beats         pattern, nibble i = beats[4i+3:4i], nonzero = programmed
//   beat_count    current playhead beat
//   cursor_index  beat under edit (used only with CURSOR_BLINK_EN)
//   cursor_valid  cursor display request (used only with CURSOR_BLINK_EN)
//   row_outputs   row drive, active-high, one-hot or zero
//   col_outputs   column sink, active-low (0 = LED on)
//   frame_start   one-cycle pulse when a row 0 slot begins
module led_matrix_driver #(
  parameter int NUM_BEATS    = 16,
  parameter int SCAN_DIV     = 3000,
  parameter int BLANK_CYCLES = 64,
  parameter int DIM_DUTY     = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BEATS*4-1:0] beats,
  input  logic [3:0]             beat_count,
  input  logic [3:0]             cursor_index,
  input  logic                   cursor_valid,
  output logic [3:0]             row_outputs,
  output logic [3:0]             col_outputs,
  output logic                   frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_t;

  slot_t                  state, state_next;
  logic [DIV_W-1:0]       div_cnt, div_next;
  logic [1:0]             row_sel, row_next;
  logic [3:0]             pwm_cnt, pwm_next;
  logic [NUM_BEATS*4-1:0] snap_beats;
  logic [3:0]             snap_beat_count;
  logic [3:0]             row_out_next, col_out_next;
  logic                   frame_next;

  logic                   frame_begin;
  logic                   slot_end;
  logic                   dim_on;
  logic [NUM_BEATS*4-1:0] cur_beats;
  logic [3:0]             cur_beat_count;
  logic [3:0]             led_on;

  assign frame_begin = (div_cnt == '0) && (row_sel == 2'd0);
  assign slot_end    = (div_cnt == DIV_LAST);
  assign dim_on      = int'(pwm_cnt) < DIM_DUTY;

  // The snapshot register loads on frame_begin. On that same cycle the
  // render logic looks at the live inputs. That cycle is normally blanked,
  // but the bypass keeps the frame consistent even with BLANK_CYCLES = 0.
  assign cur_beats      = frame_begin ? beats      : snap_beats;
  assign cur_beat_count = frame_begin ? beat_count : snap_beat_count;

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [3:0]         snap_cursor_index;
  logic               snap_cursor_valid;
  logic [3:0]         cur_cursor_index;
  logic               cur_cursor_valid;

  assign cur_cursor_index = frame_begin ? cursor_index : snap_cursor_index;
  assign cur_cursor_valid = frame_begin ? cursor_valid : snap_cursor_valid;

  // The counter advances at the end of each completed frame. A phase
  // therefore spans BLINK_FRAMES whole frames, starting with the first
  // frame after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt         <= '0;
      blink_phase       <= 1'b0;
      snap_cursor_index <= 4'd0;
      snap_cursor_valid <= 1'b0;
    end else begin
      if (frame_begin) begin
        snap_cursor_index <= cursor_index;
        snap_cursor_valid <= cursor_valid;
      end
      if (slot_end && (row_sel == 2'd3)) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_index, cursor_valid};
`endif

  // Per-column LED decision for the row being scanned.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [3:0] beat_idx;
    logic       programmed;
    assign beat_idx   = {row_sel, 2'(gi)};
    assign programmed = cur_beats[beat_idx*4 +: 4] != 4'd0;
`ifdef CURSOR_BLINK_EN
    assign led_on[gi] = (cur_cursor_valid && (beat_idx == cur_cursor_index))
                        ? blink_phase
                        : ((beat_idx == cur_beat_count) || (programmed && dim_on));
`else
    assign led_on[gi] = (beat_idx == cur_beat_count) || (programmed && dim_on);
`endif
  end

  always_comb begin
    div_next     = slot_end ? '0 : div_cnt + 1'b1;
    row_next     = slot_end ? row_sel + 2'd1 : row_sel;
    state_next   = (div_next < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
    // pwm_cnt stays at 0 through BLANK, so every DRIVE phase starts at 0.
    pwm_next     = ((state == SLOT_BLANK) || (state_next == SLOT_BLANK))
                   ? 4'd0 : pwm_cnt + 4'd1;
    row_out_next = 4'b0000;
    col_out_next = 4'b1111;
    frame_next   = frame_begin;
    if (state == SLOT_DRIVE) begin
      row_out_next = 4'b0001 << row_sel;
      col_out_next = ~led_on;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= (BLANK_CYCLES > 0) ? SLOT_BLANK : SLOT_DRIVE;
      div_cnt         <= '0;
      row_sel         <= 2'd0;
      pwm_cnt         <= 4'd0;
      snap_beats      <= '0;
      snap_beat_count <= 4'd0;
      row_outputs     <= 4'b0000;
      col_outputs     <= 4'b1111;
      frame_start     <= 1'b0;
    end else begin
      state       <= state_next;
      div_cnt     <= div_next;
      row_sel     <= row_next;
      pwm_cnt     <= pwm_next;
      row_outputs <= row_out_next;
      col_outputs <= col_out_next;
      frame_start <= frame_next;
      if (frame_begin) begin
        snap_beats      <= beats;
        snap_beat_count <= beat_count;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_driver.sv
module tb_led_matrix_driver;
  localparam int SD = 16;
  localparam int BC = 2;
  localparam int DD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] beats = '0;
  logic [3:0]  beat_count = 4'd0;
  logic [3:0]  cursor_index = 4'd0;
  logic        cursor_valid = 1'b0;
  logic [3:0]  row_outputs;
  logic [3:0]  col_outputs;
  logic        frame_start;

  led_matrix_driver #(
    .NUM_BEATS(16), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .DIM_DUTY(DD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .beats(beats), .beat_count(beat_count),
    .cursor_index(cursor_index), .cursor_valid(cursor_valid),
    .row_outputs(row_outputs), .col_outputs(col_outputs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;  // cycles elapsed since reset release, in scan time

  // Frame snapshot held by the model.
  logic [63:0] s_beats = '0;
  logic [3:0]  s_bc = 4'd0;
  logic [3:0]  s_ci = 4'd0;
  logic        s_cv = 1'b0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // One clock: the model computes what the outputs must show after this
  // edge, then the outputs are sampled 1 time unit past the edge.
  task automatic tick();
    logic [3:0] er, ec;
    logic       ef, on;
    int         div, row, frame, pwm, b;
    er = 4'b0000; ec = 4'b1111; ef = 1'b0;
    if (rst_n) begin
      div   = k % SD;
      row   = (k / SD) % 4;
      frame = k / FR;
      if (k % FR == 0) begin
        s_beats = beats; s_bc = beat_count; s_ci = cursor_index; s_cv = cursor_valid;
        $display("frame %0d: beats=%h beat=%0d cursor=%0d valid=%0b",
                 frame, beats, beat_count, cursor_index, cursor_valid);
      end
      ef = (k % FR == 0);
      if (div >= BC) begin
        er  = 4'(1 << row);
        pwm = (div - BC) % 16;
        for (int c = 0; c < 4; c++) begin
          b  = row * 4 + c;
          on = (b == int'(s_bc)) || ((s_beats[b*4 +: 4] != 4'd0) && (pwm < DD));
`ifdef CURSOR_BLINK_EN
          if (s_cv && (b == int'(s_ci))) on = ((frame / BF) % 2) == 1;
`endif
          ec[c] = ~on;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("row_outputs", row_outputs, er);
    chk("col_outputs", col_outputs, ec);
    chk("frame_start", {3'b000, frame_start}, {3'b000, ef});
    if (rst_n) k++;
    else k = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 16; i++)
      beats[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    beat_count   = 4'($urandom);
    cursor_index = 4'($urandom);
    cursor_valid = 1'($urandom);
  endtask

  initial begin
    // Reset held for 5 cycles, with the playhead scenario already applied.
    rst_n = 1'b0;
    beats = '0; beat_count = 4'd5;
    run(5);
    rst_n = 1'b1;
    run(2 * FR);

    // Dim level: beat 0 programmed, playhead on beat 15.
    beats = 64'h3; beat_count = 4'd15;
    run(2 * FR);

    // Snapshot: playhead moves mid-frame during row 2.
    beats = '0; beat_count = 4'd5;
    run(FR);
    while (k % FR != 2 * SD + 5) tick();
    beat_count = 4'd6;
    run(2 * FR);

    // Cursor request on beat 0 across several blink phases.
    cursor_valid = 1'b1; cursor_index = 4'd0; beats = '0; beat_count = 4'd9;
    run(5 * FR);

    // Random patterns with inputs changing at arbitrary cycles.
    for (int i = 0; i < 8 * FR; i++) begin
      if ($urandom_range(0, 19) == 0) rand_inputs();
      tick();
    end

    // Reset in the middle of a row 2 DRIVE phase.
    while (k % FR != 2 * SD + BC + 5) tick();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    rand_inputs();
    run(2 * FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_driver.md
Name: led_matrix_driver

Overview:
- Drives the 4x4 beat-indicator LED matrix by row scanning. It is the output-direction counterpart of the button matrix scanner: it reads the 64-bit pattern and the playhead rather than sensing key presses.
- Beat i maps to row i[3:2] and column i[1:0], the same layout as button_index.
- Shows four things: programmed beats dim, playhead full brightness, unprogrammed beats off, and an optional blinking edit cursor.

Parameters:
- NUM_BEATS, 16, number of beats; fixed at 16 for the 4x4 matrix.
- SCAN_DIV, 3000, clk cycles per row slot. At 12 MHz this gives 4 kHz rows and a 1 kHz frame rate.
- BLANK_CYCLES, 64, cycles at the start of each row slot with all columns off (anti-ghosting). Must be less than SCAN_DIV.
- DIM_DUTY, 4, on-count out of 16 for the dim PWM level.
- BLINK_FRAMES, 250, frames per cursor blink toggle.

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  synchronous reset, active-low
- beats  in  NUM_BEATS*4  pattern; nibble i = beats[4i+3:4i]; nonzero means programmed
- beat_count  in  4  current playhead beat
- cursor_index  in  4  beat under edit
- cursor_valid  in  1  cursor display request
- row_outputs  out  4  row drive, active-high, one-hot or zero
- col_outputs  out  4  column sink, active-low (0 = LED on)
- frame_start  out  1  one-cycle pulse when a row 0 slot begins

Behaviour:
Clocking and reset:
- Single clock domain. All outputs are registered.
- When rst_n=0 at a posedge, the next cycle has: row_outputs=4'b0000, col_outputs=4'b1111, frame_start=0. Also cleared: div_cnt=0, row_sel=0, pwm_cnt=0, blink_cnt=0, blink_phase=0, snapshot=0.
- This holds for reset at any point, including mid-slot. After release, scanning restarts at row 0 in BLANK.

Row-slot timing:
- div_cnt counts 0..SCAN_DIV-1.
- When div_cnt hits SCAN_DIV-1, it wraps to 0 and row_sel increments modulo 4.

Per-slot states:
- BLANK while div_cnt < BLANK_CYCLES:
  - row_outputs=0, col_outputs=4'hF.
  - pwm_cnt is held at 0.
- DRIVE otherwise:
  - row_outputs is one-hot at bit row_sel.
  - pwm_cnt is a 4-bit counter, incrementing every cycle and wrapping freely.

Snapshot:
- On the cycle div_cnt==0 with row_sel==0, register beats, beat_count, cursor_index and cursor_valid into the snapshot.
- The whole frame renders from this snapshot, so mid-frame input changes never tear.

frame_start:
- Asserted for exactly the cycle on which row 0 BLANK begins.
- The first such pulse occurs 1 cycle after reset release.
- Period is 4*SCAN_DIV cycles.

Per-LED value during DRIVE, for beat b = {row_sel, col}, priority highest first:
1. Cursor (CURSOR_BLINK_EN only): snapshot cursor_valid and b==cursor_index → on if blink_phase=1, off if blink_phase=0.
2. Playhead: b==beat_count → on.
3. Programmed: nibble b != 0 → on when pwm_cnt < DIM_DUTY.
4. Otherwise off.
- col_outputs[col] is the inverse of the on value.
- Output latency: 1 cycle from internal state.

Boundaries:
- DIM_DUTY=0 → programmed beats never lit.
- DIM_DUTY>=16 → programmed beats always on.
- beat_count wraps 15→0 across a frame boundary: takes effect at the next snapshot.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - blink_cnt counts frame_start pulses 0..BLINK_FRAMES-1.
  - On wrap, blink_phase toggles.
  - Cursor priority rule applies.
- Undefined:
  - cursor_index and cursor_valid are ignored.
  - No blink_cnt or blink_phase logic is synthesized.
  - Rendering uses priorities 2–4 only.

Test Plan:
Parameters for all scenarios: SCAN_DIV=16, BLANK_CYCLES=2, DIM_DUTY=4, BLINK_FRAMES=2.
1. Reset timing: hold rst_n=0 for 5 cycles, then release → next cycle row_outputs=0 and col_outputs=F. Then frame_start pulses once every 64 cycles, and row_outputs follows 0001, 0010, 0100, 1000, each active for 14 of 16 cycles.
2. Playhead: beats=0, beat_count=5 → only in the row 1 DRIVE cycles, col_outputs=4'b1101; all other rows F.
3. Dim level: beats nibble 0 = 4'h3, beat_count=15 → during row 0, col_outputs[0]=0 on exactly 4 of every 16 consecutive DRIVE cycles. Row 3, col 3 is on continuously during its DRIVE cycles.
4. Snapshot: change beat_count from 5 to 6 mid-frame (during row 2) → current frame still shows beat 5; next frame shows beat 6.
5. Cursor (CURSOR_BLINK_EN defined): cursor_valid=1, cursor_index=0, beats=0, beat_count=9 → beat 0 is off for 2 frames, on for 2 frames, and repeats. With the macro undefined, beat 0 stays off.
6. Reset mid-DRIVE in row 2 → next cycle all outputs off; the restart frame begins at row 0 with a frame_start pulse.
